// File: rtl/display_transmitter.sv
// Eight-digit multiplexed seven-segment and LED driver.
// New frames are buffered and swapped in only at a frame boundary.
module display_transmitter #(
    parameter int REFRESH_CLOCKS = 100_000,
    parameter int DIGITS         = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4*DIGITS-1:0]   data_i,
    input  logic [DIGITS-1:0]     en_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [15:0]           led_i,
    output logic [DIGITS-1:0]     an_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [15:0]           led_o
);

    localparam int CW = (REFRESH_CLOCKS > 1) ? $clog2(REFRESH_CLOCKS) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_CLOCKS - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   act_data;
    logic [DIGITS-1:0]     act_en;
    logic [DIGITS-1:0]     act_dp;
    logic [4*DIGITS-1:0]   pend_data;
    logic [DIGITS-1:0]     pend_en;
    logic [DIGITS-1:0]     pend_dp;
    logic                  pend_full;

    logic       tick;
    logic       frame_end;
    logic       accept;
    logic       lit;
    logic [3:0] nib;

    assign tick      = (cnt == CNT_MAX);
    assign frame_end = tick && (idx == IDX_MAX);
    assign accept    = valid_i && !pend_full;
    assign lit       = act_en[idx];
    assign nib       = act_data[4*idx +: 4];
    assign ready_o   = ~pend_full;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt       <= '0;
            idx       <= '0;
            act_data  <= '0;
            act_en    <= '0;
            act_dp    <= '0;
            pend_data <= '0;
            pend_en   <= '0;
            pend_dp   <= '0;
            pend_full <= 1'b0;
            an_o      <= '1;
            seg_o     <= 7'h7F;
            dp_o      <= 1'b1;
            led_o     <= '0;
        end else begin
            if (tick) begin
                cnt <= '0;
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // accept needs an empty buffer, commit a full one: never both
            if (accept) begin
                pend_data <= data_i;
                pend_en   <= en_i;
                pend_dp   <= dp_i;
                pend_full <= 1'b1;
            end else if (frame_end && pend_full) begin
                act_data  <= pend_data;
                act_en    <= pend_en;
                act_dp    <= pend_dp;
                pend_full <= 1'b0;
            end

            if (lit) begin
                an_o  <= ~(DIGITS'(1) << idx);
                seg_o <= hex7(nib);
                dp_o  <= ~act_dp[idx];
            end else begin
                an_o  <= '1;
                seg_o <= 7'h7F;
                dp_o  <= 1'b1;
            end
            led_o <= led_i;
        end
    end

endmodule

// File: tb/tb_display_transmitter.sv
// Bench for display_transmitter: directed plan items plus random
// traffic, all outputs compared each cycle with a frame-level model.
module tb_display_transmitter;

    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic [7:0]  en;
    logic [7:0]  dpm;
    logic        valid;
    logic        ready;
    logic [15:0] led;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] led_q;

    always #5 clk = ~clk;

    display_transmitter #(.REFRESH_CLOCKS(R), .DIGITS(8)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .data_i  (data),
        .en_i    (en),
        .dp_i    (dpm),
        .valid_i (valid),
        .ready_o (ready),
        .led_i   (led),
        .an_o    (an),
        .seg_o   (seg),
        .dp_o    (dp),
        .led_o   (led_q)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    logic [6:0] hexrom [16];
    initial hexrom = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                       7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21,
                       7'h06, 7'h0E};

    // model: display position is pure arithmetic on cycles since reset
    int          m_t;
    int          m_k;
    logic        m_pf;
    logic [31:0] m_pd, m_ad;
    logic [7:0]  m_pe, m_ae, m_pp, m_ap;
    logic [3:0]  m_nib;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [15:0] e_led;

    always @(posedge clk) begin
        if (rst) begin
            m_t = 0; m_pf = 1'b0;
            m_ad = '0; m_ae = '0; m_ap = '0;
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_led = '0;
        end else begin
            m_k = (m_t / R) % 8;
            if (m_ae[m_k]) begin
                m_nib = m_ad[4*m_k +: 4];
                e_an  = ~(8'd1 << m_k);
                e_seg = hexrom[m_nib];
                e_dp  = ~m_ap[m_k];
            end else begin
                e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
            end
            e_led = led;
            if (valid && !m_pf) begin
                m_pd = data; m_pe = en; m_pp = dpm; m_pf = 1'b1;
            end else if (m_pf && (m_t % (8*R)) == 8*R-1) begin
                m_ad = m_pd; m_ae = m_pe; m_ap = m_pp; m_pf = 1'b0;
            end
            m_t++;
        end
    end

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("an", an, e_an);
            check("seg", seg, e_seg);
            check("dp", dp, e_dp);
            check("ready", ready, !m_pf);
            check("led", led_q, e_led);
        end
    end

    task automatic wait_ready(input int max);
        int n = 0;
        while (!ready && n < max) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", ready, 1);
    endtask

    task automatic pulse(input logic [31:0] d, input logic [7:0] e,
                         input logic [7:0] p);
        data = d; en = e; dpm = p; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; data = '0; en = '0; dpm = '0; valid = 1'b0; led = '0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (34) @(negedge clk);

        pulse(32'h0123_4567, 8'hFF, 8'h01);
        check("rdy_drop", ready, 0);
        wait_ready(100);
        @(negedge clk);
        check("d0_an", an, 8'hFE);
        check("d0_seg", seg, 7'h78);
        check("d0_dp", dp, 0);
        repeat (4) @(negedge clk);
        check("d1_an", an, 8'hFD);
        check("d1_seg", seg, 7'h02);
        check("d1_dp", dp, 1);
        repeat (30) @(negedge clk);

        wait_ready(100);
        pulse(32'h89AB_CDEF, 8'h0F, 8'hF0);
        wait_ready(100);
        repeat (40) @(negedge clk);

        data = 32'hAAAA_AAAA; en = 8'hFF; dpm = 8'h00; valid = 1'b1;
        @(negedge clk);
        data = 32'hBBBB_BBBB;
        repeat (70) @(negedge clk);
        valid = 1'b0;
        repeat (40) @(negedge clk);

        wait_ready(100);
        pulse(32'h1234_5678, 8'hFF, 8'hFF);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", ready, 1);
        check("rst_an", an, 8'hFF);
        repeat (40) @(negedge clk);

        led = 16'hA5A5;
        @(negedge clk);
        led = 16'h5A5A;
        check("led_a5", led_q, 16'hA5A5);
        @(negedge clk);
        check("led_5a", led_q, 16'h5A5A);

        for (int i = 0; i < 3000; i++) begin
            data  = $urandom;
            en    = 8'($urandom);
            dpm   = 8'($urandom);
            valid = ($urandom % 4) == 0;
            led   = 16'($urandom);
            rst   = ($urandom % 600) == 0;
            @(negedge clk);
        end
        rst = 1'b0;
        valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
